mem_arbiter: RTL
================

# mem_arbiter

Parametrised arbiter between N cache-line requestors (I-cache, D-cache, and future clients such as a prefetcher) and the single burst-memory port. It grants one whole-line transaction at a time under round-robin or fixed priority, serialises write lines into beats, deserialises read beats into a line, and returns a one-cycle response to the granted requestor. Beat packing and unpacking is done internally; no external line assembler is needed.

## Interface
- NUM_PORTS, 2, number of requestors (≥1); port 0 is the D-cache in the default build
- ADDR_W, 32, address width
- LINE_W, 256, cache line width in bits
- BEAT_W, 64, memory beat width; LINE_W must be a multiple of BEAT_W; BEATS = LINE_W/BEAT_W

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_addr  in  NUM_PORTS*ADDR_W  per-port line address, port p at [p*ADDR_W +: ADDR_W]
- req_read  in  NUM_PORTS  per-port read request
- req_write  in  NUM_PORTS  per-port write request
- req_wdata  in  NUM_PORTS*LINE_W  per-port write line
- req_rdata  out  LINE_W  read line, shared by all ports, valid with req_resp
- req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse
- bmem_addr  out  ADDR_W  line-aligned burst address
- bmem_read  out  1  read burst request
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BEAT_W  write beat
- bmem_ready  in  1  memory accepts read request or write beat this cycle
- bmem_rdata  in  BEAT_W  read beat
- bmem_rvalid  in  1  read beat valid

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR, DONE.
- IDLE: port p is requesting if req_read[p] | req_write[p]. Selects one port, latches its address (low log2(LINE_W/8) bits cleared), write line, and direction, then moves to WR if req_write, else to RD_REQ. A port asserting both read and write is treated as a write.
- RD_REQ: bmem_read=1, bmem_addr=latched address; remain until bmem_ready=1, then go to RD_DATA with beat counter 0.
- RD_DATA: on each bmem_rvalid, store bmem_rdata at [k*BEAT_W +: BEAT_W] and increment k. After beat BEATS-1, go to DONE.
- WR: bmem_write=1, bmem_wdata=beat k of the latched line, bmem_addr=latched address. k advances on bmem_ready. After beat BEATS-1 is accepted, go to DONE.
- DONE: req_resp[grant]=1 for exactly one cycle, req_rdata=assembled line on a read (0 on a write), then go to IDLE.
- Requestors hold request, address and wdata until their resp pulse and deassert in the following cycle. Requests that arrive during a transaction wait; none are lost.
- Round-robin pointer = last granted port. Search starts at pointer+1, modulo NUM_PORTS. The pointer updates at grant.
- bmem_rvalid outside RD_DATA and bmem_ready outside RD_REQ/WR are ignored.

## Timing
- Reset (rst=0 at a clk edge): state=IDLE, k=0, RR pointer=NUM_PORTS-1, all outputs 0, latched line cleared. Reset mid-transaction abandons the burst; partial beats are discarded and no resp is issued.
- Read, minimum: request seen in IDLE at cycle 0, bmem_read at cycle 1 (ready=1), beats at cycles 2..BEATS+1, resp at cycle BEATS+2.
- Write, minimum: grant at cycle 0, beats at cycles 1..BEATS, resp at cycle BEATS+1.
- Back-to-back: the earliest new grant is the cycle after DONE. Minimum one IDLE cycle between transactions.
- All outputs are functions of registered state only; there are no combinational paths from req_* to bmem_*.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration as above.
- Undefined: fixed priority; the lowest-numbered requesting port always wins, and the pointer logic is compiled out.

## Test plan
- Single read, port 1, addr 0x1ECEB004, beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr=0x1ECEB000, req_rdata={0x44..,0x33..,0x22..,0x11..}, req_resp=2'b10 at cycle 6.
- Port 0 write, line 0xAAAA..BBBB, bmem_ready toggling 1,0,1,1,1 -> four beats issued low first, none repeated or skipped, resp=2'b01 one cycle after last accept.
- Ports 0 and 1 request simultaneously, repeatedly, under MEM_ARB_RR_EN -> grants alternate 0,1,0,1. Without the macro, port 0 wins every time port 0 is requesting.
- NUM_PORTS=3, LINE_W=512: all ports request -> grants 0,1,2; each read collects 8 beats.
- rst=0 during RD_DATA after 2 beats -> next cycle all outputs 0, no resp. A fresh read then completes correctly.
- Stray bmem_rvalid in IDLE -> ignored; the next read line contains no stray data.

Source files
------------

// File: rtl/mem_arbiter.sv
// Whole-line arbiter from NUM_PORTS cache requestors onto one burst-memory port.
// Define MEM_ARB_RR_EN for round-robin grants; otherwise the lowest requesting port wins.
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256,
  parameter int BEAT_W    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [ADDR_W-1:0]           bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [BEAT_W-1:0]           bmem_wdata,
  input  logic                        bmem_ready,
  input  logic [BEAT_W-1:0]           bmem_rdata,
  input  logic                        bmem_rvalid
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF   = $clog2(LINE_W / 8);

  localparam logic [PW-1:0]     LAST_PORT  = PW'(NUM_PORTS - 1);
  localparam logic [KW-1:0]     LAST_BEAT  = KW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              wr_q, wr_d;
`ifdef MEM_ARB_RR_EN
  logic [PW-1:0]     ptr_q, ptr_d;
`endif

  logic [ADDR_W-1:0]    port_addr  [NUM_PORTS];
  logic [LINE_W-1:0]    port_wdata [NUM_PORTS];
  logic [BEAT_W-1:0]    line_beat  [BEATS];
  logic [NUM_PORTS-1:0] port_req;
  logic                 sel_found;
  logic [PW-1:0]        sel_port;

  assign port_req = req_read | req_write;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign port_wdata[gi] = req_wdata[gi*LINE_W +: LINE_W];
      assign req_resp[gi]   = (state_q == S_DONE) && (grant_q == PW'(gi));
    end
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign line_beat[gi] = line_q[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  // Walk the ports once, starting just past the last grant (or at port 0).
  always_comb begin : arbitrate
    logic [PW-1:0] cand;
`ifdef MEM_ARB_RR_EN
    cand = (ptr_q == LAST_PORT) ? '0 : ptr_q + 1'b1;
`else
    cand = '0;
`endif
    sel_found = 1'b0;
    sel_port  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!sel_found && port_req[cand]) begin
        sel_found = 1'b1;
        sel_port  = cand;
      end
      cand = (cand == LAST_PORT) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    line_d  = line_q;
    wr_d    = wr_q;
`ifdef MEM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = sel_port;
          addr_d  = port_addr[sel_port] & ALIGN_MASK;
          line_d  = port_wdata[sel_port];
          wr_d    = req_write[sel_port];
          k_d     = '0;
          state_d = req_write[sel_port] ? S_WR : S_RD_REQ;
`ifdef MEM_ARB_RR_EN
          ptr_d   = sel_port;
`endif
        end
      end
      S_RD_REQ: begin
        if (bmem_ready) begin
          k_d     = '0;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bmem_rvalid) begin
          for (int b = 0; b < BEATS; b++) begin
            if (k_q == KW'(b)) line_d[b*BEAT_W +: BEAT_W] = bmem_rdata;
          end
          if (k_q == LAST_BEAT) begin
            k_d     = '0;
            state_d = S_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_WR: begin
        if (bmem_ready) begin
          if (k_q == LAST_BEAT) begin
            k_d     = '0;
            state_d = S_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      wr_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= LAST_PORT;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      wr_q    <= wr_d;
`ifdef MEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Outputs decode registered state only, so no request input reaches the memory port.
  assign bmem_read  = (state_q == S_RD_REQ);
  assign bmem_write = (state_q == S_WR);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? line_beat[k_q] : '0;
  assign req_rdata  = ((state_q == S_DONE) && !wr_q) ? line_q : '0;

endmodule
